// File: rtl/datapath.sv
// Multicycle CPU datapath: PC, IR, MDR, A, B, ALUOut, a 16x32 register file and the ALU,
// all advanced by the per-cycle control word from Control.
module datapath #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWriteCond,
    input  logic        PCWrite,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        IRWrite,
    input  logic        RegWrite,
    input  logic        Instr26,
    input  logic        RegSelect1,
    input  logic [1:0]  PCSource,
    input  logic [1:0]  ALUOp,
    input  logic [1:0]  ALUSrcA,
    input  logic [1:0]  ALUSrcB,
    input  logic [1:0]  RegSelect2,
    output logic [5:0]  opcode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out
);
    localparam logic [5:0] OpBeq = 6'b100000;
    localparam logic [5:0] OpBne = 6'b100001;
    localparam logic [5:0] OpBlt = 6'b100010;

    logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [31:0] rf_q [16];

    logic [3:0]  rd, rs1, rs2, rsel1, rsel2;
    logic [13:0] imm14;
    logic [25:0] off26;
    logic [31:0] rdata1, rdata2, imm_ext, alu_a, alu_b, alu_res, pc_next;
    logic        pc_en;

    assign opcode = ir_q[31:26];
    assign rd     = ir_q[25:22];
    assign rs1    = ir_q[21:18];
    assign rs2    = ir_q[17:14];
    assign imm14  = ir_q[13:0];
    assign off26  = ir_q[25:0];

    assign rsel1 = RegSelect1 ? rd : rs1;

    always_comb begin
        rsel2 = 4'd0;
        case (RegSelect2)
            2'b00:   rsel2 = rs2;
            2'b01:   rsel2 = rd;
            2'b10:   rsel2 = rs1;
            default: rsel2 = 4'd0;
        endcase
    end

    // R0 is hardwired to zero on both read ports.
    assign rdata1 = (rsel1 == 4'd0) ? 32'd0 : rf_q[rsel1];
    assign rdata2 = (rsel2 == 4'd0) ? 32'd0 : rf_q[rsel2];

    assign imm_ext = Instr26 ? {{6{off26[25]}}, off26} : {{18{imm14[13]}}, imm14};

    always_comb begin
        alu_a = 32'd0;
        case (ALUSrcA)
            2'b00:   alu_a = pc_q;
            2'b01:   alu_a = a_q;
            2'b10:   alu_a = 32'd0;
            default: alu_a = aluout_q;
        endcase
        alu_b = 32'd0;
        case (ALUSrcB)
            2'b00:   alu_b = b_q;
            2'b01:   alu_b = 32'd1;
            2'b10:   alu_b = imm_ext;
            default: alu_b = {imm14, 16'h0};
        endcase
        alu_res = 32'd0;
        case (ALUOp)
            2'b00:   alu_res = alu_a + alu_b;
            2'b01:   alu_res = alu_a - alu_b;
            2'b10:   alu_res = alu_a & alu_b;
            default: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
        endcase
    end

    always_comb begin
        pc_next = alu_res;
        case (PCSource)
            2'b00:   pc_next = alu_res;
            2'b01:   pc_next = aluout_q;
            2'b10:   pc_next = {pc_q[31:26], off26};
            default: pc_next = a_q;
        endcase
        // Conditional update only fires for the three branch opcodes.
        pc_en = PCWrite;
        if (!PCWrite && PCWriteCond) begin
            case (opcode)
                OpBeq:   pc_en = (alu_res == 32'd0);
                OpBne:   pc_en = (alu_res != 32'd0);
                OpBlt:   pc_en = alu_res[0];
                default: pc_en = 1'b0;
            endcase
        end
    end

    assign mem_addr  = IRWrite ? pc_q : aluout_q;
    assign mem_wdata = b_q;
    assign mem_we    = MemWrite;
    assign pc_out    = pc_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            mdr_q    <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            a_q      <= rdata1;
            b_q      <= rdata2;
            aluout_q <= alu_res;
            if (IRWrite) begin
                ir_q <= mem_rdata;
            end else begin
                mdr_q <= mem_rdata;
            end
            if (pc_en) begin
                pc_q <= pc_next;
            end
            if (RegWrite && (rd != 4'd0)) begin
                rf_q[rd] <= MemtoReg ? mdr_q : aluout_q;
            end
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed walk through the main instruction flows,
// then randomized control words compared cycle by cycle against an architectural model.
module tb_datapath;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic        PCWriteCond, PCWrite, MemWrite, MemtoReg, IRWrite, RegWrite, Instr26;
    logic        RegSelect1;
    logic [1:0]  PCSource, ALUOp, ALUSrcA, ALUSrcB, RegSelect2;
    logic [5:0]  opcode;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic        mem_we;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model state.
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_alu_out;
    logic [31:0] m_rf [16];
    bit          model_valid = 1'b0;

    datapath #(.RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite), .Instr26(Instr26),
        .RegSelect1(RegSelect1), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegSelect2(RegSelect2), .opcode(opcode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .pc_out(pc_out)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rf_read(input logic [3:0] k);
        return (k == 4'd0) ? 32'd0 : m_rf[k];
    endfunction

    task automatic model_step();
        logic [3:0]  rd, rs1, rs2;
        logic [31:0] pa, pb, opa, opb, res, imm, npc;
        bit          take;
        if (!reset) begin
            m_pc = RESET_PC;
            m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_alu_out = 0;
            foreach (m_rf[k]) m_rf[k] = 0;
            model_valid = 1'b1;
            return;
        end
        rd  = m_ir[25:22];
        rs1 = m_ir[21:18];
        rs2 = m_ir[17:14];
        pa  = rf_read(RegSelect1 ? rd : rs1);
        pb  = (RegSelect2 == 0) ? rf_read(rs2) : (RegSelect2 == 1) ? rf_read(rd) :
              (RegSelect2 == 2) ? rf_read(rs1) : 32'd0;
        if (Instr26) begin
            imm = {6'h0, m_ir[25:0]};
            if (m_ir[25]) imm = imm - 32'h0400_0000;
        end else begin
            imm = {18'h0, m_ir[13:0]};
            if (m_ir[13]) imm = imm - 32'h0000_4000;
        end
        opa = (ALUSrcA == 0) ? m_pc : (ALUSrcA == 1) ? m_a : (ALUSrcA == 2) ? 32'd0 : m_alu_out;
        opb = (ALUSrcB == 0) ? m_b : (ALUSrcB == 1) ? 32'd1 : (ALUSrcB == 2) ? imm
              : m_ir[13:0] * 32'h0001_0000;
        case (ALUOp)
            0: res = opa + opb;
            1: res = opa - opb;
            2: res = opa & opb;
            default: res = (int'(opa) < int'(opb)) ? 32'd1 : 32'd0;
        endcase
        npc = (PCSource == 0) ? res : (PCSource == 1) ? m_alu_out :
              (PCSource == 2) ? {m_pc[31:26], m_ir[25:0]} : m_a;
        take = PCWrite ||
               (PCWriteCond && ((m_ir[31:26] == 6'h20 && res == 0) ||
                                (m_ir[31:26] == 6'h21 && res != 0) ||
                                (m_ir[31:26] == 6'h22 && res[0])));
        if (RegWrite && rd != 0) m_rf[rd] = MemtoReg ? m_mdr : m_alu_out;
        m_a = pa;
        m_b = pb;
        m_alu_out = res;
        if (IRWrite) m_ir = mem_rdata;
        else m_mdr = mem_rdata;
        if (take) m_pc = npc;
    endtask

    // Check outputs for the applied control word, advance the model, then take the edge.
    task automatic step();
        #1;
        if (model_valid) begin
            check_eq("opcode", {26'h0, opcode}, {26'h0, m_ir[31:26]});
            check_eq("mem_addr", mem_addr, IRWrite ? m_pc : m_alu_out);
            check_eq("mem_wdata", mem_wdata, m_b);
            check_eq("mem_we", {31'h0, mem_we}, {31'h0, MemWrite});
            check_eq("pc_out", pc_out, m_pc);
        end
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctrl();
        reset = 1'b1;
        PCWriteCond = 0; PCWrite = 0; MemWrite = 0; MemtoReg = 0; IRWrite = 0;
        RegWrite = 0; Instr26 = 0; RegSelect1 = 0;
        PCSource = 0; ALUOp = 0; ALUSrcA = 0; ALUSrcB = 0; RegSelect2 = 0;
    endtask

    task automatic load_ir(input logic [31:0] v);
        clear_ctrl(); IRWrite = 1; mem_rdata = v; step();
    endtask

    // Reads register k through B onto mem_wdata; clobbers IR.
    task automatic read_reg(input logic [3:0] k, output logic [31:0] val);
        load_ir({6'h0, k, 22'h0});
        clear_ctrl(); RegSelect2 = 2'b01; step();
        val = mem_wdata;
    endtask

    task automatic write_reg(input logic [3:0] k, input logic [31:0] v);
        load_ir({6'h0, k, 22'h0});
        clear_ctrl(); mem_rdata = v; step();
        clear_ctrl(); RegWrite = 1; MemtoReg = 1; step();
    endtask

    initial begin
        logic [31:0] v;
        mem_rdata = $urandom();
        clear_ctrl();
        // Reset with every strobe asserted.
        reset = 0;
        PCWriteCond = 1; PCWrite = 1; MemWrite = 1; MemtoReg = 1; IRWrite = 1;
        RegWrite = 1; Instr26 = 1; RegSelect1 = 1;
        PCSource = 3; ALUOp = 3; ALUSrcA = 3; ALUSrcB = 3; RegSelect2 = 3;
        step();
        step();
        clear_ctrl();
        #1;
        check_eq("rst_pc", pc_out, 32'h0);
        check_eq("rst_opcode", {26'h0, opcode}, 32'h0);
        check_eq("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        for (int k = 1; k < 16; k++) begin
            read_reg(4'(k), v);
            check_eq("rst_reg", v, 32'h0);
        end

        // Fetch ADDI R1, R1, 5 at PC 0 (IR was clobbered by the reads, PC still 0).
        clear_ctrl(); mem_rdata = 32'hC844_0005; IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b01;
        step();
        check_eq("fetch_opcode", {26'h0, opcode}, 32'h32);
        check_eq("fetch_pc", pc_out, 32'h1);

        // R1 = 7 via MDR, then ADDI execute and writeback.
        clear_ctrl(); mem_rdata = 32'd7; step();
        clear_ctrl(); RegWrite = 1; MemtoReg = 1; step();
        clear_ctrl(); step();
        clear_ctrl(); ALUSrcA = 2'b01; ALUSrcB = 2'b10; step();
        clear_ctrl(); #1; check_eq("addi_aluout", mem_addr, 32'd12);
        RegWrite = 1; step();
        clear_ctrl(); RegSelect2 = 2'b01; step();
        check_eq("addi_r1", mem_wdata, 32'd12);

        // BEQ taken, BNE not taken, with A=B=R2=3.
        write_reg(4'd2, 32'd3);
        load_ir({6'b100000, 4'd0, 4'd2, 4'd2, 14'd40});
        clear_ctrl(); ALUSrcA = 2'b10; ALUSrcB = 2'b10; step();
        clear_ctrl(); ALUSrcA = 2'b01; ALUOp = 2'b01; PCWriteCond = 1; PCSource = 2'b01; step();
        check_eq("beq_pc", pc_out, 32'd40);
        load_ir({6'b100001, 4'd0, 4'd2, 4'd2, 14'd50});
        clear_ctrl(); ALUSrcA = 2'b10; ALUSrcB = 2'b10; step();
        clear_ctrl(); ALUSrcA = 2'b01; ALUOp = 2'b01; PCWriteCond = 1; PCSource = 2'b01; step();
        check_eq("bne_pc", pc_out, 32'd40);

        // R0 write of 9 is dropped (IR rd is still 0).
        clear_ctrl(); mem_rdata = 32'd9; step();
        clear_ctrl(); RegWrite = 1; MemtoReg = 1; step();
        clear_ctrl(); RegSelect2 = 2'b01; step();
        check_eq("r0_zero", mem_wdata, 32'd0);

        // SW then LW path.
        write_reg(4'd3, 32'hDEAD_BEEF);
        load_ir({6'b101011, 4'd3, 4'd0, 4'd0, 14'd8});
        clear_ctrl(); RegSelect2 = 2'b01; ALUSrcA = 2'b10; ALUSrcB = 2'b10; step();
        clear_ctrl(); MemWrite = 1; #1;
        check_eq("sw_addr", mem_addr, 32'd8);
        check_eq("sw_we", {31'h0, mem_we}, 32'h1);
        check_eq("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        clear_ctrl(); mem_rdata = 32'h1234; step();
        clear_ctrl(); RegWrite = 1; MemtoReg = 1; step();
        clear_ctrl(); RegSelect2 = 2'b01; step();
        check_eq("lw_rd", mem_wdata, 32'h1234);

        // Jump via A to FFFFFFFF, then PC+1 wraps to 0.
        write_reg(4'd6, 32'hFFFF_FFFF);
        clear_ctrl(); RegSelect1 = 1; step();
        clear_ctrl(); PCSource = 2'b11; PCWrite = 1; step();
        check_eq("jr_pc", pc_out, 32'hFFFF_FFFF);
        clear_ctrl(); PCWrite = 1; ALUSrcB = 2'b01; step();
        check_eq("pc_wrap", pc_out, 32'h0);

        // J to 0x100, then reset mid-instruction.
        load_ir({6'b000010, 26'h100});
        clear_ctrl(); PCSource = 2'b10; PCWrite = 1; step();
        check_eq("j_pc", pc_out, 32'h100);
        load_ir({6'h0, 4'd5, 22'h0});
        clear_ctrl(); mem_rdata = 32'h55; step();
        clear_ctrl(); reset = 0; RegWrite = 1; MemtoReg = 1; PCWrite = 1; IRWrite = 1; step();
        clear_ctrl(); #1;
        check_eq("midrst_pc", pc_out, 32'h0);
        check_eq("midrst_opcode", {26'h0, opcode}, 32'h0);
        read_reg(4'd5, v);
        check_eq("midrst_r5", v, 32'h0);
        read_reg(4'd3, v);
        check_eq("midrst_r3", v, 32'h0);

        // Randomized control words against the model.
        for (int n = 0; n < 1500; n++) begin
            reset       = ($urandom_range(0, 79) != 0);
            PCWriteCond = 1'($urandom_range(0, 1));
            PCWrite     = ($urandom_range(0, 3) == 0);
            MemWrite    = 1'($urandom_range(0, 1));
            MemtoReg    = 1'($urandom_range(0, 1));
            IRWrite     = ($urandom_range(0, 2) == 0);
            RegWrite    = 1'($urandom_range(0, 1));
            Instr26     = 1'($urandom_range(0, 1));
            RegSelect1  = 1'($urandom_range(0, 1));
            PCSource    = 2'($urandom_range(0, 3));
            ALUOp       = 2'($urandom_range(0, 3));
            ALUSrcA     = 2'($urandom_range(0, 3));
            ALUSrcB     = 2'($urandom_range(0, 3));
            RegSelect2  = 2'($urandom_range(0, 3));
            mem_rdata   = $urandom();
            if ($urandom_range(0, 1) == 1) mem_rdata[31:26] = {4'b1000, 2'($urandom_range(0, 3))};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
